// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port: one request in flight,
// fixed LATENCY, response held until accepted. Define DMEM_ERR_EN to add the resp_err port.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic        resp_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [31:0]       Mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic              r_write;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    logic              w_req_ready_nxt;
    logic              w_resp_valid_nxt;
    logic [31:0]       w_resp_rdata_nxt;
    logic              w_resp_err_nxt;

    logic              w_accept;
    logic              w_commit;
    logic              w_handshake;
    logic              w_mem_we;
    logic              w_req_err;
    logic              w_unused;

    // req_ready is only ever high in IDLE, so it doubles as the accept qualifier
    assign w_accept    = req_valid && r_req_ready;
    assign w_commit    = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_handshake = (r_state == S_RESP) && r_resp_valid && resp_ready;

`ifdef DMEM_ERR_EN
    assign w_req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
`else
    assign w_req_err = 1'b0;
`endif

    assign w_unused = ^{req_addr[1:0], req_addr[31:ADDR_W+2], r_resp_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    // Request fields are captured only on the accepting edge
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_idx   <= req_addr[ADDR_W+1:2];
            r_wdata <= req_wdata;
            r_err   <= w_req_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (w_handshake) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_req_ready_nxt  = (w_state_nxt == S_IDLE);
        w_resp_valid_nxt = (w_state_nxt == S_RESP);
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        w_mem_we         = 1'b0;
        if (w_commit) begin
            w_mem_we         = r_write && !r_err && !rst;
            w_resp_rdata_nxt = (r_write || r_err) ? 32'h0 : Mem[r_idx];
            w_resp_err_nxt   = r_err;
        end else if (w_handshake) begin
            w_resp_rdata_nxt = 32'h0;
            w_resp_err_nxt   = 1'b0;
        end
    end

    // Storage is deliberately outside reset so contents survive it
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            Mem[r_idx] <= r_wdata;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
`ifdef DMEM_ERR_EN
    assign resp_err   = r_resp_err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, backpressure, reset mid-operation,
// address wrap, and (with DMEM_ERR_EN) misaligned/out-of-range error responses.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
`ifdef DMEM_ERR_EN
    logic        resp_err;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata)
`ifdef DMEM_ERR_EN
        ,
        .resp_err   (resp_err)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(req_ready), 32'd1);
    endtask

    // Issue one request, check latency/backpressure timing; data is checked by the monitor
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int hold);
        logic [31:0] first;
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        exp_q.push_back({exp_err, exp_rd});
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = 1'b0;
                req_write = ~wr;
                req_addr  = 32'hFFFF_FFFC;
                req_wdata = 32'h5A5A_5A5A;
            end
            check("lat_valid", 32'(resp_valid), 32'(c == LAT));
            check("busy_ready", 32'(req_ready), 32'd0);
        end
        first = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", resp_rdata, first);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("done_valid", 32'(resp_valid), 32'd0);
        check("done_data", resp_rdata, 32'h0);
        check("idle_ready", 32'(req_ready), 32'd1);
    endtask

    // Monitor: pops an expectation on every response handshake
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got %08h expected no response", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e[31:0]);
`ifdef DMEM_ERR_EN
                    check("resp_err", 32'(resp_err), 32'(e[32]));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        dut.Mem[64] = 32'hDEADBEEF;
        dut.Mem[66] = 32'hF0F0F0F0;
        dut.Mem[68] = 32'hCAFEF00D;
        dut.Mem[69] = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        issue(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        issue(1'b1, 32'h104, 32'h12345678, 32'h0, 1'b0, 0);
        check("mem65", dut.Mem[65], 32'h12345678);
        issue(1'b0, 32'h104, 32'h0, 32'h12345678, 1'b0, 1);
        issue(1'b0, 32'h108, 32'h0, 32'hF0F0F0F0, 1'b0, 5);

        // Reset while the store is still waiting: it must be dropped
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h110;
        req_wdata = 32'hAAAA5555;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wrst_valid", 32'(resp_valid), 32'd0);
        check("wrst_ready0", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("wrst_ready1", 32'(req_ready), 32'd1);
        repeat (LAT + 1) @(negedge clk);
        check("wrst_valid_late", 32'(resp_valid), 32'd0);
        check("mem68", dut.Mem[68], 32'hCAFEF00D);

        // Reset while a committed store's response is pending: memory keeps the store
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h114;
        req_wdata = 32'h11223344;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("rrst_pending", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rrst_valid", 32'(resp_valid), 32'd0);
        check("mem69", dut.Mem[69], 32'h11223344);

`ifdef DMEM_ERR_EN
        issue(1'b0, 32'h500, 32'h0, 32'h0, 1'b1, 0);
        issue(1'b1, 32'h102, 32'h99999999, 32'h0, 1'b1, 0);
        check("mem64_err", dut.Mem[64], 32'hDEADBEEF);
`else
        issue(1'b0, 32'h500, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        issue(1'b1, 32'h102, 32'h99999999, 32'h0, 1'b0, 0);
        check("mem64_wrap", dut.Mem[64], 32'h99999999);
`endif

        repeat (5) @(negedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
